// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control and data bundle for the universal shift register
//    master : drives en, mode, sr_in, sl_in, pdata_in; observes the outputs
//    slave  : the shift register itself
//    WIDTH  : register length, must match the attached univ_shift_reg
interface univ_shift_reg_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH);
   logic             en;
   logic [1:0]       mode;
   logic             sr_in;
   logic             sl_in;
   logic [WIDTH-1:0] pdata_in;
   logic [WIDTH-1:0] q;
   logic             so_r;
   logic             so_l;
   logic [CW-1:0]    bit_cnt;
   logic             frame_done;
   logic             parity;
   modport master (
      output en, mode, sr_in, sl_in, pdata_in,
      input  q, so_r, so_l, bit_cnt, frame_done, parity
   );
   modport slave (
      input  en, mode, sr_in, sl_in, pdata_in,
      output q, so_r, so_l, bit_cnt, frame_done, parity
   );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register (hold / shift right / shift left / load) with frame counter
//    clk        : rising-edge clock
//    rst_n      : asynchronous active-low reset, q=RESET_VAL, bit_cnt=0, frame_done=0
//    bus.en     : clock enable, 0 holds q and bit_cnt and clears frame_done
//    bus.mode   : 00 hold, 01 shift right (sr_in -> msb), 10 shift left (sl_in -> lsb), 11 load pdata_in
//    bus.q      : register contents, so_r = q[0], so_l = q[WIDTH-1]
//    bus.bit_cnt: shifts completed in the current frame, cleared by a load
//    bus.frame_done: registered pulse the cycle after the WIDTH-th shift of a frame
//    bus.parity : ^q when SHIFTREG_PARITY_EN is defined, otherwise tied to 0
module univ_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic              clk,
   input logic              rst_n,
   univ_shift_reg_if.slave  bus
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   logic [WIDTH-1:0] q_r, q_nxt;
   logic [CW-1:0]    cnt_r, cnt_nxt;
   logic             fd_r, fd_nxt;
   logic             shift, load, last;
   always_comb begin
      shift   = bus.en && (bus.mode[1] ^ bus.mode[0]);
      load    = bus.en && (bus.mode == 2'b11);
      last    = cnt_r == LAST;
      q_nxt   = load                             ? bus.pdata_in :
                (shift && bus.mode == 2'b01)     ? {bus.sr_in, q_r[WIDTH-1:1]} :
                shift                            ? {q_r[WIDTH-2:0], bus.sl_in} : q_r;
      // direction changes do not restart the frame; only a load does
      cnt_nxt = load ? '0 : shift ? (last ? '0 : cnt_r + CW'(1)) : cnt_r;
      fd_nxt  = shift && last;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r   <= RESET_VAL;
         cnt_r <= '0;
         fd_r  <= 1'b0;
      end else begin
         q_r   <= q_nxt;
         cnt_r <= cnt_nxt;
         fd_r  <= fd_nxt;
      end
   end
   assign bus.q          = q_r;
   assign bus.so_r       = q_r[0];
   assign bus.so_l       = q_r[WIDTH-1];
   assign bus.bit_cnt    = cnt_r;
   assign bus.frame_done = fd_r;
`ifdef SHIFTREG_PARITY_EN
   assign bus.parity = ^q_r;
`else
   assign bus.parity = 1'b0;
`endif
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed and randomized check of univ_shift_reg against a behavioural model
module tb_univ_shift_reg;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [7:0] m_q;
   int         m_cnt;
   logic       m_fd;
   univ_shift_reg_if #(.WIDTH(8)) bus ();
   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic exp_parity(input logic [7:0] v);
`ifdef SHIFTREG_PARITY_EN
      return logic'($countones(v) % 2);
`else
      return 1'b0;
`endif
   endfunction
   task automatic check_all();
      check("q", bus.q, m_q);
      check("so_r", bus.so_r, m_q % 2);
      check("so_l", bus.so_l, m_q / 128);
      check("bit_cnt", bus.bit_cnt, m_cnt);
      check("frame_done", bus.frame_done, m_fd);
      check("parity", bus.parity, exp_parity(m_q));
   endtask
   task automatic model_reset();
      m_q = 8'h00; m_cnt = 0; m_fd = 1'b0;
   endtask
   task automatic step(input logic e, input logic [1:0] m, input logic s_r, input logic s_l,
                       input logic [7:0] pd);
      bus.en = e; bus.mode = m; bus.sr_in = s_r; bus.sl_in = s_l; bus.pdata_in = pd;
      @(posedge clk);
      m_fd = 1'b0;
      if (e && m == 2'b11) begin
         m_q = pd; m_cnt = 0;
      end else if (e && (m == 2'b01 || m == 2'b10)) begin
         m_q = (m == 2'b01) ? 8'((m_q >> 1) + (s_r ? 128 : 0)) : 8'(((m_q * 2) + s_l) % 256);
         m_cnt++;
         if (m_cnt == 8) begin
            m_cnt = 0; m_fd = 1'b1;
         end
      end
      #1;
      check_all();
   endtask
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge clk) rst_n = 1'b1;
   endtask
   initial begin
      logic [7:0] exp_so, pat, frozen;
      bus.en = 1'b0; bus.mode = 2'b00; bus.sr_in = 1'b0; bus.sl_in = 1'b0; bus.pdata_in = 8'h00;
      model_reset();
      #3 check_all();
      @(negedge clk) rst_n = 1'b1;
      // reset asserted mid-frame with q loaded
      step(1, 2'b11, 0, 0, 8'h5B);
      step(1, 2'b01, 1, 0, 0);
      step(1, 2'b10, 0, 1, 0);
      async_reset();
      check("rst_q", bus.q, 8'h00);
      // load 0xA5 then shift right out of so_r
      step(1, 2'b11, 0, 0, 8'hA5);
      check("load_a5", bus.q, 8'hA5);
      check("load_cnt", bus.bit_cnt, 0);
      exp_so = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         check("so_r_seq", bus.so_r, exp_so[i]);
         step(1, 2'b01, 0, 0, 0);
         if (i < 7) check("fd_early", bus.frame_done, 0);
      end
      check("sisr_q", bus.q, 8'h00);
      check("sisr_fd", bus.frame_done, 1);
      step(1, 2'b00, 0, 0, 0);
      check("fd_pulse_end", bus.frame_done, 0);
      // shift left pattern into q
      pat = 8'b1101_0010;
      for (int i = 7; i >= 0; i--) step(1, 2'b10, 0, pat[i], 0);
      check("left_q", bus.q, 8'hD2);
      check("left_fd", bus.frame_done, 1);
      step(1, 2'b10, 0, 0, 0);
      check("ninth_cnt", bus.bit_cnt, 1);
      check("ninth_fd", bus.frame_done, 0);
      // pause with en=0 mid-frame
      step(1, 2'b11, 0, 0, 8'h96);
      for (int i = 0; i < 3; i++) step(1, 2'b01, 1, 0, 0);
      frozen = bus.q;
      for (int i = 0; i < 5; i++) begin
         step(0, 2'($urandom_range(3)), 1, 1, 8'hFF);
         check("pause_q", bus.q, frozen);
         check("pause_cnt", bus.bit_cnt, 3);
      end
      for (int i = 0; i < 5; i++) begin
         step(1, 2'b10, 1, 0, 0);
         check("resume_fd", bus.frame_done, i == 4);
      end
      // a load restarts the frame
      for (int i = 0; i < 4; i++) step(1, 2'b01, 0, 0, 0);
      step(1, 2'b11, 0, 0, 8'h3C);
      check("reload_q", bus.q, 8'h3C);
      check("reload_cnt", bus.bit_cnt, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, 2'b01, 0, 0, 0);
         check("reload_fd", bus.frame_done, i == 7);
      end
      // parity
      step(1, 2'b11, 0, 0, 8'h07);
`ifdef SHIFTREG_PARITY_EN
      check("parity_07", bus.parity, 1);
`else
      check("parity_07", bus.parity, 0);
`endif
      step(1, 2'b11, 0, 0, 8'h03);
      check("parity_03", bus.parity, 0);
      // randomized traffic with occasional async reset
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(3) != 0, 2'($urandom_range(3)), 1'($urandom), 1'($urandom),
              8'($urandom));
         if ($urandom_range(60) == 0) async_reset();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
